// File: rtl/rv32_pkg.sv
// Shared RV32IM decode/execute definitions: opcodes, ALU op encoding, funct fields,
// system words and the registered execute payload.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_IMM, WB_PC_IMM, WB_LINK} wb_sel_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd_addr;
    logic            reg_write;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] store_data;
    logic            is_load;
    logic            is_store;
    logic [2:0]      load_type;
    logic [2:0]      store_type;
    logic            branch_taken;
    logic [XLEN-1:0] pc_target;
    logic            is_div;
    logic [1:0]      div_op;
    logic            illegal;
    logic            halt;
    logic            misaligned;
  } ex_out_t;

  // funct3 (+ alt bit for SUB/SRA, m bit for the multiply group) to ALU op
  function automatic alu_op_e alu_op_from_f3(logic [2:0] f3, logic alt, logic m);
    alu_op_e op;
    op = ALU_ADD;
    if (m) begin
      case (f3[1:0])
        2'b00:   op = ALU_MUL;
        2'b01:   op = ALU_MULH;
        2'b10:   op = ALU_MULHSU;
        default: op = ALU_MULHU;
      endcase
    end else begin
      case (f3)
        3'b000:  op = alt ? ALU_SUB : ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLT;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = alt ? ALU_SRA : ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/rv32_decode_execute_if.sv
// Operand/instruction input bundle and registered execute results of the decode/execute stage.
interface rv32_decode_execute_if;
  import rv32_pkg::*;

  logic            valid_in;
  logic            stall;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            valid_out;
  logic [4:0]      rd_addr;
  logic            reg_write;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] store_data;
  logic            is_load;
  logic            is_store;
  logic [2:0]      load_type;
  logic [2:0]      store_type;
  logic            branch_taken;
  logic [XLEN-1:0] pc_target;
  logic            is_div;
  logic [1:0]      div_op;
  logic            illegal;
  logic            halt;
  logic            misaligned;

  modport master (
    output valid_in, stall, instr, pc, rs1_val, rs2_val,
    input  rs1_addr, rs2_addr, valid_out, rd_addr, reg_write, result, mem_addr,
           store_data, is_load, is_store, load_type, store_type, branch_taken,
           pc_target, is_div, div_op, illegal, halt, misaligned
  );

  modport slave (
    input  valid_in, stall, instr, pc, rs1_val, rs2_val,
    output rs1_addr, rs2_addr, valid_out, rd_addr, reg_write, result, mem_addr,
           store_data, is_load, is_store, load_type, store_type, branch_taken,
           pc_target, is_div, div_op, illegal, halt, misaligned
  );
endinterface

// File: rtl/rv32_alu.sv
// Combinational RV32IM integer ALU (no division; division goes to an external unit).
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] result
);

  logic [4:0]  shamt;
  logic        a_signed;
  logic        b_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  assign shamt = b[4:0];

  // One 64-bit multiplier; the high-half variants differ only in operand extension
  always_comb begin
    a_signed = (alu_op == ALU_MULH) || (alu_op == ALU_MULHSU);
    b_signed = (alu_op == ALU_MULH);
    a_ext    = {{32{a_signed & a[31]}}, a};
    b_ext    = {{32{b_signed & b[31]}}, b};
    prod     = a_ext * b_ext;
  end

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << shamt;
      ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'd0, a < b};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> shamt;
      ALU_SRA:    result = 32'($signed(a) >>> shamt);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_MUL:    result = prod[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result = prod[63:32];
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_decode_execute.sv
// RV32IM decode + execute stage: combinational decode/ALU/branch feeding one output register
// that forms the ID/EX -> EX/MEM boundary.
module rv32_decode_execute
  import rv32_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  rv32_decode_execute_if.slave bus
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [XLEN-1:0] imm;
  alu_op_e         alu_op;
  wb_sel_e         wb_sel;
  logic            use_imm;
  logic            illegal_c;
  logic            writes_rd;
  logic            is_load_c;
  logic            is_store_c;
  logic            jump_c;
  logic            jalr_c;
  logic            branch_c;
  logic            div_c;
  logic            halt_c;
  logic            br_cond;

  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mem_addr_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] wb_val;
  logic            misaligned_c;

  ex_out_t ex_d, ex_q;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];

  assign bus.rs1_addr = bus.instr[19:15];
  assign bus.rs2_addr = bus.instr[24:20];

  assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7], bus.instr[30:25],
                  bus.instr[11:8], 1'b0};
  assign imm_u = {bus.instr[31:12], 12'd0};
  assign imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12], bus.instr[20],
                  bus.instr[30:21], 1'b0};

  // Instruction decode: immediate format, ALU op, writeback source and legality
  always_comb begin
    imm        = '0;
    alu_op     = ALU_ADD;
    wb_sel     = WB_ALU;
    use_imm    = 1'b0;
    illegal_c  = 1'b0;
    writes_rd  = 1'b0;
    is_load_c  = 1'b0;
    is_store_c = 1'b0;
    jump_c     = 1'b0;
    jalr_c     = 1'b0;
    branch_c   = 1'b0;
    div_c      = 1'b0;
    halt_c     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm = imm_u; wb_sel = WB_IMM; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        imm = imm_u; wb_sel = WB_PC_IMM; writes_rd = 1'b1;
      end
      OPC_JAL: begin
        imm = imm_j; wb_sel = WB_LINK; writes_rd = 1'b1; jump_c = 1'b1;
      end
      OPC_JALR: begin
        imm = imm_i; wb_sel = WB_LINK; writes_rd = 1'b1; jump_c = 1'b1; jalr_c = 1'b1;
      end
      OPC_BRANCH: begin
        imm = imm_b; branch_c = 1'b1;
        if (!(funct3 inside {BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU}))
          illegal_c = 1'b1;
      end
      OPC_LOAD: begin
        imm = imm_i; use_imm = 1'b1; writes_rd = 1'b1; is_load_c = 1'b1;
        if (!(funct3 inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU}))
          illegal_c = 1'b1;
      end
      OPC_STORE: begin
        imm = imm_s; use_imm = 1'b1; is_store_c = 1'b1;
        if (!(funct3 inside {ST_SB, ST_SH, ST_SW}))
          illegal_c = 1'b1;
      end
      OPC_OP_IMM: begin
        imm = imm_i; use_imm = 1'b1; writes_rd = 1'b1;
        alu_op = alu_op_from_f3(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT), 1'b0);
        if ((funct3 == 3'b001) && (funct7 != F7_BASE))
          illegal_c = 1'b1;
        if ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT))
          illegal_c = 1'b1;
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        case (funct7)
          F7_BASE:   alu_op = alu_op_from_f3(funct3, 1'b0, 1'b0);
          F7_ALT: begin
            alu_op = alu_op_from_f3(funct3, 1'b1, 1'b0);
            if ((funct3 != 3'b000) && (funct3 != 3'b101))
              illegal_c = 1'b1;
          end
          F7_MULDIV: begin
            alu_op = alu_op_from_f3(funct3, 1'b0, 1'b1);
            div_c  = funct3[2];
          end
          default:   illegal_c = 1'b1;
        endcase
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if ((bus.instr == ECALL_WORD) || (bus.instr == EBREAK_WORD))
          halt_c = 1'b1;
        else
          illegal_c = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      BR_BEQ:  br_cond = (bus.rs1_val == bus.rs2_val);
      BR_BNE:  br_cond = (bus.rs1_val != bus.rs2_val);
      BR_BLT:  br_cond = ($signed(bus.rs1_val) <  $signed(bus.rs2_val));
      BR_BGE:  br_cond = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
      BR_BLTU: br_cond = (bus.rs1_val <  bus.rs2_val);
      BR_BGEU: br_cond = (bus.rs1_val >= bus.rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

  assign alu_b      = use_imm ? imm : bus.rs2_val;
  assign mem_addr_c = bus.rs1_val + imm;
  assign target_c   = jalr_c ? (mem_addr_c & 32'hFFFF_FFFE) : (bus.pc + imm);

  rv32_alu u_alu (
    .a      (bus.rs1_val),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_res)
  );

  always_comb begin
    wb_val = alu_res;
    case (wb_sel)
      WB_IMM:    wb_val = imm;
      WB_PC_IMM: wb_val = bus.pc + imm;
      WB_LINK:   wb_val = bus.pc + 32'd4;
      default:   wb_val = alu_res;
    endcase
    if (div_c)
      wb_val = '0;
  end

  assign misaligned_c = (is_load_c | is_store_c) &
                        (((funct3[1:0] == 2'b10) && (mem_addr_c[1:0] != 2'b00)) ||
                         ((funct3[1:0] == 2'b01) && mem_addr_c[0]));

  // Next output register value: hold on stall, clear on bubble, squash control on illegal
  always_comb begin
    ex_d = ex_q;
    if (!bus.stall) begin
      ex_d = '0;
      if (bus.valid_in) begin
        ex_d.valid        = 1'b1;
        ex_d.rd_addr      = rd;
        ex_d.illegal      = illegal_c;
        ex_d.reg_write    = !illegal_c && writes_rd && (rd != 5'd0);
        ex_d.result       = wb_val;
        ex_d.mem_addr     = mem_addr_c;
        ex_d.store_data   = bus.rs2_val;
        ex_d.is_load      = !illegal_c && is_load_c;
        ex_d.is_store     = !illegal_c && is_store_c;
        ex_d.load_type    = funct3;
        ex_d.store_type   = funct3;
        ex_d.branch_taken = !illegal_c && (jump_c || (branch_c && br_cond));
        ex_d.pc_target    = target_c;
        ex_d.is_div       = !illegal_c && div_c;
        ex_d.div_op       = funct3[1:0];
        ex_d.halt         = !illegal_c && halt_c;
        ex_d.misaligned   = misaligned_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign bus.valid_out    = ex_q.valid;
  assign bus.rd_addr      = ex_q.rd_addr;
  assign bus.reg_write    = ex_q.reg_write;
  assign bus.result       = ex_q.result;
  assign bus.mem_addr     = ex_q.mem_addr;
  assign bus.store_data   = ex_q.store_data;
  assign bus.is_load      = ex_q.is_load;
  assign bus.is_store     = ex_q.is_store;
  assign bus.load_type    = ex_q.load_type;
  assign bus.store_type   = ex_q.store_type;
  assign bus.branch_taken = ex_q.branch_taken;
  assign bus.pc_target    = ex_q.pc_target;
  assign bus.is_div       = ex_q.is_div;
  assign bus.div_op       = ex_q.div_op;
  assign bus.illegal      = ex_q.illegal;
  assign bus.halt         = ex_q.halt;
  assign bus.misaligned   = ex_q.misaligned;

endmodule

// File: tb/tb_rv32_decode_execute.sv
// Scoreboard bench for rv32_decode_execute: directed cases plus random instructions checked
// against an instruction-level reference model.
module tb_rv32_decode_execute;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int unsigned cyc = 0;

  rv32_decode_execute_if bus ();

  rv32_decode_execute dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    ex_out_t     e;
    bit          c_all, c_rd, c_res, c_mem, c_tgt, c_div, c_mis;
    int unsigned tag;
  } sb_t;

  sb_t sbq[$];
  sb_t last_exp;
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic sb_t blank();
    sb_t r;
    r.e = '0;
    r.c_all = 0; r.c_rd = 0; r.c_res = 0; r.c_mem = 0; r.c_tgt = 0; r.c_div = 0; r.c_mis = 0;
    r.tag = 0;
    return r;
  endfunction

  function automatic logic [31:0] arith(input logic [2:0] f3, input bit alt, input bit m,
                                        input logic [31:0] x, input logic [31:0] y);
    longint ps;
    longint unsigned pu;
    if (m) begin
      case (f3)
        3'd0: return x * y;
        3'd1: begin ps = longint'($signed(x)) * longint'($signed(y)); return ps[63:32]; end
        3'd2: begin ps = longint'($signed(x)) * longint'({32'd0, y}); return ps[63:32]; end
        3'd3: begin pu = {32'd0, x} * {32'd0, y}; return pu[63:32]; end
        default: return 32'd0;
      endcase
    end
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  // Architectural model of one valid instruction
  function automatic sb_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                input logic [31:0] a, input logic [31:0] b);
    sb_t r;
    logic [6:0]  opc = ins[6:0];
    logic [4:0]  rd  = ins[11:7];
    logic [2:0]  f3  = ins[14:12];
    logic [6:0]  f7  = ins[31:25];
    logic [31:0] iimm = 32'($signed(ins[31:20]));
    logic [31:0] simm = 32'($signed({ins[31:25], ins[11:7]}));
    logic [31:0] bimm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    logic [31:0] uimm = {ins[31:12], 12'h000};
    logic [31:0] jimm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    logic [31:0] wb = 0, addr = 0, tgt = 0;
    bit legal = 1, wrc = 0, ld = 0, st = 0, tk = 0, dv = 0, hlt = 0, ctl = 0;
    r = blank();
    case (opc)
      7'h37: begin wb = uimm; wrc = 1; end
      7'h17: begin wb = pcv + uimm; wrc = 1; end
      7'h6F: begin wb = pcv + 4; wrc = 1; tk = 1; tgt = pcv + jimm; ctl = 1; end
      7'h67: begin wb = pcv + 4; wrc = 1; tk = 1; tgt = (a + iimm) & ~32'd1; ctl = 1; end
      7'h63: begin
        tgt = pcv + bimm; ctl = 1;
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = !($signed(a) < $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = !(a < b);
          default: legal = 0;
        endcase
      end
      7'h03: begin
        addr = a + iimm; wb = addr; wrc = 1; ld = 1;
        legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      end
      7'h23: begin
        addr = a + simm; st = 1;
        legal = (f3 <= 2);
      end
      7'h13: begin
        wrc = 1;
        wb = arith(f3, (f3 == 5) && (f7 == 7'h20), 0, a, iimm);
        if (f3 == 1 && f7 != 0) legal = 0;
        if (f3 == 5 && f7 != 0 && f7 != 7'h20) legal = 0;
      end
      7'h33: begin
        wrc = 1;
        if (f7 == 0) wb = arith(f3, 0, 0, a, b);
        else if (f7 == 7'h20) begin wb = arith(f3, 1, 0, a, b); legal = (f3 == 0) || (f3 == 5); end
        else if (f7 == 1) begin dv = f3[2]; wb = dv ? 32'd0 : arith(f3, 0, 1, a, b); end
        else legal = 0;
      end
      7'h0F: ;
      7'h73: begin hlt = (ins == 32'h73) || (ins == 32'h0010_0073); legal = hlt; end
      default: legal = 0;
    endcase
    r.e.valid        = 1;
    r.e.illegal      = !legal;
    r.e.rd_addr      = rd;
    r.e.reg_write    = legal && wrc && (rd != 0);
    r.e.result       = wb;
    r.e.mem_addr     = addr;
    r.e.store_data   = b;
    r.e.is_load      = legal && ld;
    r.e.is_store     = legal && st;
    r.e.load_type    = f3;
    r.e.store_type   = f3;
    r.e.branch_taken = legal && tk;
    r.e.pc_target    = tgt;
    r.e.is_div       = legal && dv;
    r.e.div_op       = f3[1:0];
    r.e.halt         = legal && hlt;
    r.e.misaligned   = (f3[1:0] == 2'd2 && addr % 4 != 0) || (f3[1:0] == 2'd1 && addr % 2 != 0);
    r.c_rd  = legal;
    r.c_res = legal && wrc;
    r.c_mem = legal && (ld || st);
    r.c_mis = legal && (ld || st);
    r.c_tgt = legal && ctl;
    r.c_div = legal && dv;
    return r;
  endfunction

  task automatic cmp(input sb_t s);
    chk("valid_out",    32'(bus.valid_out),    32'(s.e.valid));
    chk("illegal",      32'(bus.illegal),      32'(s.e.illegal));
    chk("reg_write",    32'(bus.reg_write),    32'(s.e.reg_write));
    chk("is_load",      32'(bus.is_load),      32'(s.e.is_load));
    chk("is_store",     32'(bus.is_store),     32'(s.e.is_store));
    chk("branch_taken", 32'(bus.branch_taken), 32'(s.e.branch_taken));
    chk("is_div",       32'(bus.is_div),       32'(s.e.is_div));
    chk("halt",         32'(bus.halt),         32'(s.e.halt));
    if (s.c_all || s.c_rd)  chk("rd_addr", 32'(bus.rd_addr), 32'(s.e.rd_addr));
    if (s.c_all || s.c_res) chk("result", bus.result, s.e.result);
    if (s.c_all || s.c_mem) chk("mem_addr", bus.mem_addr, s.e.mem_addr);
    if (s.c_all || (s.c_mem && s.e.is_store)) chk("store_data", bus.store_data, s.e.store_data);
    if (s.c_all || (s.c_mem && s.e.is_load))  chk("load_type", 32'(bus.load_type), 32'(s.e.load_type));
    if (s.c_all || (s.c_mem && s.e.is_store)) chk("store_type", 32'(bus.store_type), 32'(s.e.store_type));
    if (s.c_all || s.c_tgt) chk("pc_target", bus.pc_target, s.e.pc_target);
    if (s.c_all || s.c_div) chk("div_op", 32'(bus.div_op), 32'(s.e.div_op));
    if (s.c_all || s.c_mis) chk("misaligned", 32'(bus.misaligned), 32'(s.e.misaligned));
  endtask

  // Monitor: compare every output register load whose capture edge has passed
  initial begin
    forever begin
      @(posedge clk);
      #3;
      while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
        sb_t s;
        s = sbq.pop_front();
        cmp(s);
      end
    end
  end

  task automatic step(input bit rst, input bit stl, input bit vld, input logic [31:0] ins,
                      input logic [31:0] pcv, input logic [31:0] a, input logic [31:0] b);
    sb_t ex;
    @(posedge clk);
    #1;
    reset_n = !rst; bus.stall = stl; bus.valid_in = vld;
    bus.instr = ins; bus.pc = pcv; bus.rs1_val = a; bus.rs2_val = b;
    if (rst) begin ex = blank(); ex.c_all = 1; end
    else if (stl) ex = last_exp;
    else if (!vld) ex = blank();
    else ex = model(ins, pcv, a, b);
    ex.tag = cyc + 1;
    sbq.push_back(ex);
    last_exp = ex;
    #1;
    chk("rs1_addr", 32'(bus.rs1_addr), 32'(ins[19:15]));
    chk("rs2_addr", 32'(bus.rs2_addr), 32'(ins[24:20]));
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {im, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] im, logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  f7s;
    logic [4:0]  rd  = r[11:7];
    logic [4:0]  rs1 = r[19:15];
    logic [4:0]  rs2 = r[24:20];
    logic [2:0]  f3  = r[14:12];
    case ($urandom_range(0, 3))
      0: f7s = 7'h00;
      1: f7s = 7'h20;
      2: f7s = 7'h01;
      default: f7s = r[31:25];
    endcase
    case ($urandom_range(0, 10))
      0: return r;
      1: return enc_r(f7s, rs2, rs1, f3, rd, 7'b0110011);
      2: return {f7s, rs2, rs1, f3, rd, 7'b0010011};
      3: return enc_i(r[31:20], rs1, f3, rd, 7'b0000011);
      4: return enc_s(r[31:20], rs2, rs1, f3);
      5: return enc_b({r[31:20], 1'b0}, rs2, rs1, f3);
      6: return enc_j({r[31:12], 1'b0}, rd);
      7: return enc_i(r[31:20], rs1, 3'b000, rd, 7'b1100111);
      8: return {r[31:12], rd, $urandom_range(0, 1) != 0 ? 7'b0110111 : 7'b0010111};
      9: return enc_r(7'h01, rs2, rs1, f3, rd, 7'b0110011);
      default: case ($urandom_range(0, 3))
        0: return 32'h0000_0073;
        1: return 32'h0010_0073;
        2: return {r[31:7], 7'b1110011};
        default: return {r[31:7], 7'b0001111};
      endcase
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins, pcv;
    reset_n = 1'b0; bus.stall = 1'b0; bus.valid_in = 1'b0;
    bus.instr = '0; bus.pc = '0; bus.rs1_val = '0; bus.rs2_val = '0;
    last_exp = blank();
    repeat (2) step(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    step(0, 0, 1, 32'hFFF0_0293, 32'h0, 32'h0, 32'h0);                           // ADDI x5,x0,-1
    step(0, 0, 1, enc_b(13'd8, 5'd2, 5'd1, 3'b100), 32'h100, 32'hFFFF_FFFF, 32'h1); // BLT
    step(0, 0, 1, enc_b(13'd8, 5'd2, 5'd1, 3'b110), 32'h100, 32'hFFFF_FFFF, 32'h1); // BLTU
    step(0, 0, 1, enc_i(12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111), 32'h40, 32'h2003, 32'h0);
    step(0, 0, 1, enc_i(12'd0, 5'd2, 3'b010, 5'd3, 7'b0000011), 32'h80, 32'h1002, 32'h0);
    step(0, 0, 1, enc_s(12'd0, 5'd4, 5'd2, 3'b001), 32'h84, 32'h1002, 32'hCAFE_F00D);
    step(0, 0, 1, enc_r(7'h01, 5'd2, 5'd1, 3'b011, 5'd7, 7'b0110011), 32'h88,
         32'hFFFF_FFFF, 32'hFFFF_FFFF);                                           // MULHU
    step(0, 0, 1, enc_r(7'h01, 5'd2, 5'd1, 3'b100, 5'd8, 7'b0110011), 32'h8C, 32'd7, 32'd2);
    step(0, 0, 1, 32'h0000_007F, 32'h90, 32'h1, 32'h2);                           // illegal opcode
    step(0, 0, 1, 32'h0010_0073, 32'h94, 32'h0, 32'h0);                           // EBREAK
    step(0, 0, 1, enc_j(21'h1FFFFC, 5'd0), 32'h98, 32'h0, 32'h0);                 // JAL x0,-4
    step(0, 1, 1, 32'hFFF0_0293, 32'h9C, 32'h5, 32'h5);                           // stall holds
    step(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(1, 1, 1, 32'hFFF0_0293, 32'hA0, 32'h5, 32'h5);                           // reset beats stall
    step(0, 0, 1, 32'h0000_0073, 32'hA4, 32'h0, 32'h0);                           // ECALL
    step(0, 0, 0, 32'hFFF0_0293, 32'hA8, 32'h0, 32'h0);                           // bubble

    for (int i = 0; i < 600; i++) begin
      int unsigned r = $urandom_range(0, 99);
      ins = rand_instr();
      pcv = $urandom;
      pcv = pcv & 32'hFFFF_FFFC;
      step(r < 2, (r >= 2) && (r < 12), $urandom_range(0, 9) != 0, ins, pcv, rand_val(), rand_val());
    end

    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #4;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_decode_execute.md
# rv32_decode_execute

Combined RV32IM decode and execute datapath: decodes one instruction per cycle, computes the ALU/immediate/link result, branch decision and target, and memory address. It sits between the register file and the memory stage. Register-file addresses are produced combinationally from the instruction. All execute outputs are registered once, forming the ID/EX→EX/MEM boundary. Operand values arrive already forwarded; division is only flagged to the external divider.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- valid_in  in  1  instruction/operands valid this cycle
- stall  in  1  hold all output registers
- instr  in  32  instruction word
- pc  in  32  address of instr
- rs1_val, rs2_val  in  32 each  forwarded operand values
- rs1_addr, rs2_addr  out  5 each  combinational, instr[19:15] / instr[24:20]
- valid_out  out  1  registered valid
- rd_addr  out  5  destination register
- reg_write  out  1  write rd
- result  out  32  writeback value
- mem_addr  out  32  rs1_val+imm
- store_data  out  32  rs2_val
- is_load, is_store  out  1 each
- load_type, store_type  out  3 each  funct3
- branch_taken  out  1  jump, or branch condition true
- pc_target  out  32  redirect address
- is_div  out  1  DIV/DIVU/REM/REMU
- div_op  out  2  funct3[1:0]
- illegal, halt, misaligned  out  1 each

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, FENCE 0001111, SYSTEM 1110011. Any other opcode → illegal.
- Immediates: I, S, B, U and J formats, sign-extended per RV32I. B and J immediates have bit 0 = 0.
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU.
  - Shifts use b[4:0].
  - SLT and MULH treat operands as signed; MULHSU treats a as signed and b as unsigned.
  - b = imm for OP-IMM/LOAD/STORE; otherwise b = rs2_val.
- OP funct7 values:
  - 0000000: base ops.
  - 0100000: SUB/SRA only.
  - 0000001: M ops. funct3 1xx of the M group → is_div=1, result=0.
  - Any other funct7 → illegal.
- OP-IMM shifts: SLLI requires funct7=0000000; SRLI/SRAI require 0000000 or 0100000. Otherwise → illegal.
- result selection:
  - LUI → imm.
  - AUIPC → pc+imm.
  - JAL/JALR → pc+4.
  - All others → ALU output.
- Branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. 010/011 → illegal.
- pc_target: JALR → (rs1_val+imm)&~1; otherwise pc+imm.
- branch_taken = JAL | JALR | (BRANCH & condition).
- Loads accept funct3 000/001/010/100/101; stores accept 000/001/010. Others → illegal.
- misaligned applies to loads/stores only:
  - word (x10) with mem_addr[1:0]≠0.
  - half (x01) with mem_addr[0]≠0.
- halt: ECALL (0x00000073) or EBREAK (0x00100073). Other SYSTEM encodings → illegal. FENCE decodes as a no-op.
- reg_write=1 only for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP (including div) with rd≠0.
- Squashing: when illegal or valid_in=0, the registered values of reg_write, is_load, is_store, branch_taken, is_div and halt are 0. illegal itself is registered only when valid_in=1.

## Timing
- Decode and execute are combinational. Outputs appear at the rising edge after inputs are presented: latency 1. rs1_addr/rs2_addr have latency 0.
- Reset (reset_n=0 at the edge): all registered outputs become 0. Reset has priority over stall.
- stall=1: all output registers hold their values, including valid_out.
- valid_in=0 and stall=0: valid_out←0 and control bits are cleared as above. Data fields are don't-care, but the design loads 0.
- Back-to-back instructions are supported with one per cycle. There is no internal state beyond the output register.

## Structure
- Shared package rv32_pkg holds:
  - opcode localparams;
  - 5-bit alu_op encoding;
  - branch, load and store funct3 constants;
  - ECALL/EBREAK words.
- Sub-module rv32_alu: combinational, inputs a, b and alu_op, output result. Decoder, branch compare and output register stay in the top level.

## Test plan
- ADDI x5,x0,-1 (0xFFF00293), valid_in=1 → next edge: rd_addr=5, reg_write=1, result=0xFFFFFFFF.
- BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=+8 → branch_taken=1, pc_target=0x108. Same operands through BLTU → branch_taken=0.
- JALR x1 with rs1_val=0x2003, imm=0, pc=0x40 → result=0x44, pc_target=0x2002, branch_taken=1.
- LW at rs1=0x1002, imm=0 → is_load=1, mem_addr=0x1002, misaligned=1. SH at 0x1002 → misaligned=0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE. DIV → is_div=1, div_op=00, result=0.
- Opcode 0x7F → illegal=1, reg_write=0. EBREAK → halt=1. reset_n=0 mid-stream → all outputs 0. stall=1 → outputs held.
